// File: rtl/ip4_axi_pkg.sv
// ip4_axi_pkg: shared burst, response and FSM state types
// for the ip4 AXI slave memory responder.
package ip4_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

endpackage

// File: rtl/ip4_axi_slv_ram.sv
// ip4_axi_slv_ram: 1W1R synchronous RAM with per-byte write enable.
// A read and a write to the same word on one edge returns the old word.
module ip4_axi_slv_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ip4_axi_slv_mem.sv
// ip4_axi_slv_mem: AXI slave responder over on-chip SRAM, OKAY/SLVERR.
// Define IP4_AXI_SLV_WAIT_EN for LFSR-driven random backpressure.
module ip4_axi_slv_mem
    import ip4_axi_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                ID_W       = 4,
    parameter int                DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE       = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);
    localparam int NB      = DATA_W / 8;
    localparam int NB_LOG2 = $clog2(NB);
    localparam int HI      = NB_LOG2 + DEPTH_LOG2;

    // Borrow bit of the subtraction flags addresses below BASE.
    function automatic logic hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] d;
        d = {1'b0, a} - {1'b0, BASE};
        return !d[ADDR_W] && ((d[ADDR_W-1:0] >> HI) == '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] idx(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'((a - BASE) >> NB_LOG2);
    endfunction

    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a,
                                               input burst_t b);
        return (b == BURST_FIXED) ? a : a + ADDR_W'(NB);
    endfunction

    wstate_t             w_st, w_nxt;
    rstate_t             r_st, r_nxt;
    logic                up, stall, b_show, r_show;
    logic [ADDR_W-1:0]   waddr, raddr, rd_addr;
    logic [ID_W-1:0]     wid, rid_q;
    logic [7:0]          wlen, wbeat, rlen, rbeat;
    burst_t              wburst, rburst;
    logic                werr, rterr, rberr;
    logic                aw_hs, w_hs, ar_hs, r_hs, rd_go;
    logic                w_last_beat, r_last_beat;
    logic [NB-1:0]       ram_we;
    logic [DATA_W-1:0]   ram_q;

`ifdef IP4_AXI_SLV_WAIT_EN
    logic [7:0] lfsr;
    logic       b_seen, r_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= 8'hA5;
            b_seen <= 1'b0;
            r_seen <= 1'b0;
        end else begin
            lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            b_seen <= (w_st == W_RESP);
            r_seen <= (r_st == R_DATA);
        end
    end

    assign stall  = lfsr[0];
    assign b_show = b_seen || !lfsr[1];
    assign r_show = r_seen || !lfsr[1];
`else
    assign stall  = 1'b0;
    assign b_show = 1'b1;
    assign r_show = 1'b1;
`endif

    // Holds readies low until the first edge with rst_n released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) up <= 1'b0;
        else        up <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_st <= W_IDLE;
            r_st <= R_IDLE;
        end else begin
            w_st <= w_nxt;
            r_st <= r_nxt;
        end
    end

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign w_last_beat = (wbeat == wlen);
    assign r_last_beat = (rbeat == rlen);

    always_comb begin
        w_nxt   = w_st;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        unique case (w_st)
            W_IDLE: begin
                awready = up && !stall;
                if (awvalid && awready) w_nxt = W_DATA;
            end
            W_DATA: begin
                wready = !stall;
                if (wvalid && wready && w_last_beat) w_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = b_show;
                if (bvalid && bready) w_nxt = W_IDLE;
            end
            default: w_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_nxt   = r_st;
        arready = 1'b0;
        rvalid  = 1'b0;
        unique case (r_st)
            R_IDLE: begin
                arready = up && !stall;
                if (arvalid && arready) r_nxt = R_WAIT;
            end
            R_WAIT: r_nxt = R_DATA;
            R_DATA: begin
                rvalid = r_show;
                if (rvalid && rready) r_nxt = r_last_beat ? R_IDLE : R_WAIT;
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    // WRAP and reserved bursts (burst[1] set) fail the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr  <= '0;
            wid    <= '0;
            wlen   <= '0;
            wbeat  <= '0;
            wburst <= BURST_FIXED;
            werr   <= 1'b0;
        end else if (aw_hs) begin
            waddr  <= awaddr;
            wid    <= awid;
            wlen   <= awlen;
            wbeat  <= '0;
            wburst <= burst_t'(awburst);
            werr   <= awburst[1];
        end else if (w_hs) begin
            waddr <= step(waddr, wburst);
            wbeat <= wbeat + 8'd1;
            if ((wlast != w_last_beat) || !hit(waddr)) werr <= 1'b1;
        end
    end

    assign ram_we  = (w_hs && hit(waddr)) ? wstrb : '0;
    assign rd_go   = ar_hs || (r_hs && !r_last_beat);
    assign rd_addr = (r_st == R_IDLE) ? araddr : step(raddr, rburst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr  <= '0;
            rid_q  <= '0;
            rlen   <= '0;
            rbeat  <= '0;
            rburst <= BURST_FIXED;
            rterr  <= 1'b0;
            rberr  <= 1'b0;
        end else begin
            if (rd_go) begin
                raddr <= rd_addr;
                rberr <= !hit(rd_addr);
            end
            if (ar_hs) begin
                rid_q  <= arid;
                rlen   <= arlen;
                rburst <= burst_t'(arburst);
                rterr  <= arburst[1];
                rbeat  <= '0;
            end else if (r_hs) begin
                rbeat <= rbeat + 8'd1;
            end
        end
    end

    ip4_axi_slv_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (idx(waddr)),
        .wdata (wdata),
        .re    (rd_go),
        .raddr (idx(rd_addr)),
        .rdata (ram_q)
    );

    assign bid   = (w_st == W_RESP) ? wid : '0;
    assign bresp = (w_st == W_RESP && werr) ? RESP_SLVERR : RESP_OKAY;
    assign rid   = (r_st == R_DATA) ? rid_q : '0;
    assign rdata = (r_st == R_DATA && !rberr) ? ram_q : '0;
    assign rresp = (r_st == R_DATA && (rberr || rterr)) ? RESP_SLVERR : RESP_OKAY;
    assign rlast = (r_st == R_DATA) && r_last_beat;

endmodule

// File: doc/ip4_axi_slv_mem.md
# ip4_axi_slv_mem

AXI slave responder backed by on-chip SRAM; it answers the `axim` master port of `ip4_rtl_core` in block-level and system benches. Write and read channels run independent state machines sharing one 1W1R memory. Responses are OKAY, or SLVERR for unsupported or out-of-range accesses. Backpressure can optionally be randomized for stress.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; byte lanes `NB = DATA_W/8`.
- `ID_W`, 4: transaction ID width.
- `DEPTH_LOG2`, 10: memory depth in `DATA_W` words.
- `BASE`, 32'h0: byte address of word 0.
- Clock and reset (already decided): one clock `clk`, input, 1, all logic on rising edge; `rst_n`, input, 1, reset asynchronous and active-low.
- `awvalid` in 1 / `awready` out 1 / `awid` in ID_W / `awaddr` in ADDR_W / `awlen` in 8 / `awburst` in 2: write address channel.
- `wvalid` in 1 / `wready` out 1 / `wdata` in DATA_W / `wstrb` in NB / `wlast` in 1: write data channel.
- `bvalid` out 1 / `bready` in 1 / `bid` out ID_W / `bresp` out 2: write response channel.
- `arvalid` in 1 / `arready` out 1 / `arid` in ID_W / `araddr` in ADDR_W / `arlen` in 8 / `arburst` in 2: read address channel.
- `rvalid` out 1 / `rready` in 1 / `rid` out ID_W / `rdata` out DATA_W / `rresp` out 2 / `rlast` out 1: read data channel.

## Operation
- **Write FSM**
  - `W_IDLE`: `awready=1`. On AW handshake, latch id, address, `len`, burst and `err=0` → `W_DATA`.
  - `W_DATA`: `wready=1`. Each W handshake writes `wdata` into the addressed word under `wstrb`, then advances the address.
  - The beat counter ends the burst at beat `len`.
  - `wlast` disagreeing with the counter on any beat sets `err`.
  - Go to `W_RESP`: `bvalid=1`, `bid` = latched id, `bresp = err ? 2'b10 : 2'b00`. Hold until `bready` → `W_IDLE`.
- **Read FSM**
  - `R_IDLE`: `arready=1`. On AR handshake, latch fields and issue a memory read → `R_WAIT`.
  - `R_WAIT`: one cycle for the synchronous RAM → `R_DATA`.
  - `R_DATA`: `rvalid=1`; `rdata`, `rresp`, `rid` are stable until `rready`.
  - `rlast=1` on beat `len`. After the last beat → `R_IDLE`; otherwise advance the address, issue the next read → `R_WAIT`.
- **Address update**
  - FIXED (2'b00): unchanged.
  - INCR (2'b01): +NB, wrapping modulo 2^ADDR_W.
  - WRAP (2'b10) and reserved (2'b11): treated as INCR, and the whole transaction returns SLVERR.
- **Range check, per beat:** word index = `(addr-BASE)>>log2(NB)`.
  - A beat below `BASE` or at index ≥ 2^DEPTH_LOG2 is suppressed (write) or returns `rdata=0` (read).
  - Such a beat sets SLVERR: for the write response, and on that read beat only.
- Unaligned addresses are aligned down to NB; no error.
- One outstanding transaction per direction; the write and read FSMs run concurrently.
- A write and a read to the same word in the same cycle: the read returns the old data.

## Timing
- **Reset** (async assert, sync deassert):
  - All outputs 0; FSMs in `IDLE`; memory contents are not cleared.
  - `awready`/`arready` rise the first cycle after `rst_n` is sampled high.
- **Read latency:** AR handshake at cycle N → first `rvalid` at N+2. Peak rate is one beat per 2 cycles.
- **Write rate:** one beat per cycle in `W_DATA`. `bvalid` is asserted the cycle after the last W handshake.
- AW is not accepted while a write is in `W_DATA`/`W_RESP`; AR is not accepted until `R_IDLE`.
- Reset mid-burst abandons the transaction: no response, partial writes remain in memory.

## Configuration
- `IP4_AXI_SLV_WAIT_EN` defined:
  - An 8-bit Fibonacci LFSR, taps 8,6,5,4, reset seed 8'hA5, steps every cycle.
  - When `lfsr[0]=1`, `awready`, `wready` and `arready` are forced low that cycle.
  - When `lfsr[1]=1`, assertion of `bvalid`/`rvalid` is delayed one cycle. Once asserted, valid is never withdrawn.
- Macro undefined: no LFSR; readies and valids follow the FSMs exactly as in Timing.

## Structure
- Shared package `ip4_axi_pkg`:
  - Burst enum `burst_t` (FIXED/INCR/WRAP/RSVD).
  - Response constants `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`.
  - Write and read FSM state enums.
- Sub-module `ip4_axi_slv_ram`: 1W1R synchronous RAM with per-byte write enable, parameterised by `DATA_W` and `DEPTH_LOG2`.

## Test plan
- **Single write/read:** write 32'hDEADBEEF to 0x10 (INCR, len 0, strb 4'hF), then read 0x10 → `bresp=OKAY`, `rdata=32'hDEADBEEF`, `rlast=1`, `rvalid` 2 cycles after AR.
- **Byte strobes:** write 32'h11223344 to 0x20, then 32'hAABBCCDD with strb 4'b0101 → read 0x20 returns 32'h11BB33DD.
- **INCR burst:** len 3 at 0x40, data 1..4, then read back with `rready` toggled every other cycle → data 1,2,3,4, `rlast` on the 4th beat only, `rdata` stable while stalled.
- **Errors:**
  - Write to index 2^DEPTH_LOG2 → `bresp=SLVERR`, memory unchanged.
  - WRAP burst → SLVERR.
  - `wlast` early on beat 1 of len 3 → SLVERR.
- **Concurrency and reset:**
  - Simultaneous AW and AR to 0x80 → read returns the old value.
  - `rst_n` pulled low mid read burst → all outputs 0 immediately; `arready=1` one cycle after release.
